// File: rtl/inst_mem_loader_if.sv
// Byte-stream in / instruction-memory write bus out for the program loader.
// The loader takes the slave view; the stream source and memory side take the master view.
interface inst_mem_loader_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              done;
  logic [CW-1:0]     word_count;
  logic              truncated;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data, done, word_count, truncated
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data, done, word_count, truncated
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Latency: wr_en the cycle after the completing byte; in_ready drops during WRITE, IDLE and DONE.
module inst_mem_loader #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  inst_mem_loader_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic              last_q, last_d;
  logic [CW-1:0]     word_count_q, word_count_d;
  logic              truncated_q, truncated_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    last_d       = last_q;
    word_count_d = word_count_q;
    truncated_d  = truncated_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d      = S_LOAD;
          word_count_d = '0;
          byte_cnt_d   = '0;
          asm_d        = '0;
          last_d       = 1'b0;
          truncated_d  = 1'b0;
        end
      end

      S_LOAD: begin
        if (bus.in_valid) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Word address and data are captured here so they are stable for the whole WRITE cycle.
          if (byte_cnt_q == 2'd3 || bus.in_last) begin
            state_d   = S_WRITE;
            last_d    = bus.in_last;
            wr_data_d = asm_d;
            wr_addr_d = ADDR_W'({word_count_q, 2'b00});
          end
        end
      end

      S_WRITE: begin
        word_count_d = word_count_q + 1'b1;
        if (last_q) begin
          state_d = S_DONE;
        end else if (word_count_q == CW'(DEPTH - 1)) begin
          state_d     = S_DONE;
          truncated_d = 1'b1;
        end else begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
          asm_d      = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      last_q       <= 1'b0;
      word_count_q <= '0;
      truncated_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      last_q       <= last_d;
      word_count_q <= word_count_d;
      truncated_q  <= truncated_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.in_ready   = (state_q == S_LOAD);
  assign bus.wr_en      = (state_q == S_WRITE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.word_count = word_count_q;
  assign bus.truncated  = truncated_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomised loads checked by a scoreboard: expected writes are queued per load,
// and an independent monitor pops and compares every wr_en it observes.
module tb_inst_mem_loader;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          need;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   acc_cnt;
  exp_t exp_q[$];
  logic [7:0] stim[$];
  int   exp_wc;
  bit   exp_tr;

  inst_mem_loader_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr=0x%08h data=0x%08h, no write expected (t=%0t)",
                   bus.wr_addr, bus.wr_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.wr_addr, e.addr);
          chk("wr_data", bus.wr_data, e.data);
          chk("bytes_accepted_at_write", acc_cnt, e.need);
          chk("in_ready_during_write", {31'd0, bus.in_ready}, 32'd0);
        end
      end
    end
  end

  // Reference model: chop the byte list into little-endian words, capped at DEPTH.
  task automatic model(input bit last);
    int n, wanted, written, need;
    logic [31:0] d;
    n       = stim.size();
    wanted  = last ? (n + 3) / 4 : n / 4;
    written = (wanted > DEPTH) ? DEPTH : wanted;
    for (int w = 0; w < written; w++) begin
      d = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) d[8 * k +: 8] = stim[4 * w + k];
      need = (4 * w + 4 < n) ? 4 * w + 4 : n;
      exp_q.push_back('{addr: 32'(4 * w), data: d, need: need});
    end
    exp_wc = written;
    exp_tr = (wanted > DEPTH) || (!last && wanted == DEPTH);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    acc_cnt   = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_after_start", {31'd0, bus.done}, 32'd0);
    chk("word_count_after_start", 32'(bus.word_count), 32'd0);
  endtask

  task automatic run_load(input bit last, input bit gaps);
    int idx, guard;
    bit acc;
    model(last);
    pulse_start();
    idx   = 0;
    guard = 0;
    while (idx < stim.size() && guard < 4000) begin
      guard++;
      if (bus.done) break;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_last  = $urandom_range(0, 1);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = stim[idx];
        bus.in_last  = last && (idx == stim.size() - 1);
      end
      bus.start = gaps && ($urandom_range(0, 5) == 0);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      bus.start = 1'b0;
      if (acc) begin
        idx++;
        acc_cnt++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    guard = 0;
    while (!bus.done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("done", {31'd0, bus.done}, 32'd1);
    // Bytes offered in DONE must be refused and cause no writes.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      chk("in_ready_in_done", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    chk("word_count", 32'(bus.word_count), 32'(exp_wc));
    chk("truncated", {31'd0, bus.truncated}, {31'd0, exp_tr});
    chk("done_held", {31'd0, bus.done}, 32'd1);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, bus.wr_en}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_truncated"}, {31'd0, bus.truncated}, 32'd0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
    chk({tag, "_wr_data"}, bus.wr_data, 32'd0);
    chk({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit last;
    int n;
    tests = 0;
    fails = 0;
    acc_cnt = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_last = 1'b0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("idle_done", {31'd0, bus.done}, 32'd0);

    // Single full word.
    stim = '{8'h13, 8'h05, 8'hA0, 8'h00};
    run_load(1'b1, 1'b0);

    // Two words plus a two-byte tail.
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hB3, 8'h02};
    run_load(1'b1, 1'b0);

    // Overflow: 36 bytes, no in_last.
    stim.delete();
    for (int i = 0; i < 36; i++) stim.push_back(8'($urandom));
    run_load(1'b0, 1'b0);

    // Exactly DEPTH words with in_last on the final byte: not truncated.
    stim.delete();
    for (int i = 0; i < 4 * DEPTH; i++) stim.push_back(8'($urandom));
    run_load(1'b1, 1'b1);

    // Randomised lengths with valid gaps and stray start pulses.
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(1, 40);
      last = (n < 32) ? 1'b1 : 1'($urandom_range(0, 1));
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      run_load(last, 1'b1);
    end

    // Asynchronous reset mid-load discards the partial word.
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      chk("in_ready_before_reset", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("post_reset_idle_done", {31'd0, bus.done}, 32'd0);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
